// File: rtl/mesh_noc_pkg.sv
// mesh_noc_pkg: shared constants and link-index helper for the mesh row link fabric.
`default_nettype none

package mesh_noc_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 64;

  typedef enum logic {
    EAST = 1'b0,
    WEST = 1'b1
  } link_dir_e;

  // East links occupy slices 0..n_links-1, west links follow at n_links..2*n_links-1.
  function automatic int link_slice(input link_dir_e dir, input int link, input int n_links);
    return (dir == EAST) ? link : (n_links + link);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_link_fifo.sv
// mesh_link_fifo: one directed link, a first-word-fall-through elastic FIFO with send/ready handshake.
// Optional per-link pop counter under MESH_LINK_CNT_EN.
`default_nettype none

module mesh_link_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_s,
  input  logic [WIDTH-1:0] in_d,
  output logic             in_r,
  output logic             out_s,
  output logic [WIDTH-1:0] out_d,
  input  logic             out_r
`ifdef MESH_LINK_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] flit_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

  // Ready comes only from registered occupancy, never from this cycle's pop.
  assign in_r  = !full && !reset;
  assign out_s = !empty && out_r && !reset;
  assign out_d = mem[rd_ptr];

  assign push = in_s && in_r;
  assign pop  = out_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_d;
  end

`ifdef MESH_LINK_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)    flit_cnt <= '0;
    else if (pop) flit_cnt <= flit_cnt + 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mesh_row_links.sv
// mesh_row_links: east and west link FIFOs between adjacent routers of one mesh row.
// Define MESH_LINK_CNT_EN to add per-link pop counters and the flit_cnt port.
`default_nettype none

module mesh_row_links
  import mesh_noc_pkg::*;
#(
  parameter int N_COLS       = 4,
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_COLS-2:0]                  e_in_s,
  input  logic [(N_COLS-1)*PACKET_WIDTH-1:0] e_in_d,
  output logic [N_COLS-2:0]                  e_in_r,
  output logic [N_COLS-2:0]                  e_out_s,
  output logic [(N_COLS-1)*PACKET_WIDTH-1:0] e_out_d,
  input  logic [N_COLS-2:0]                  e_out_r,
  input  logic [N_COLS-2:0]                  w_in_s,
  input  logic [(N_COLS-1)*PACKET_WIDTH-1:0] w_in_d,
  output logic [N_COLS-2:0]                  w_in_r,
  output logic [N_COLS-2:0]                  w_out_s,
  output logic [(N_COLS-1)*PACKET_WIDTH-1:0] w_out_d,
  input  logic [N_COLS-2:0]                  w_out_r
`ifdef MESH_LINK_CNT_EN
  ,
  output logic [2*(N_COLS-1)*CNT_WIDTH-1:0]  flit_cnt
`endif
);

  localparam int L  = N_COLS - 1;
  localparam int NL = 2 * L;
  localparam int W  = PACKET_WIDTH;

  // Flat views, indexed by link_slice(): east half low, west half high.
  logic [NL-1:0]   all_in_s;
  logic [NL*W-1:0] all_in_d;
  logic [NL-1:0]   all_in_r;
  logic [NL-1:0]   all_out_s;
  logic [NL*W-1:0] all_out_d;
  logic [NL-1:0]   all_out_r;

  assign all_in_s  = {w_in_s, e_in_s};
  assign all_in_d  = {w_in_d, e_in_d};
  assign all_out_r = {w_out_r, e_out_r};

  assign e_in_r  = all_in_r[L-1:0];
  assign w_in_r  = all_in_r[NL-1:L];
  assign e_out_s = all_out_s[L-1:0];
  assign w_out_s = all_out_s[NL-1:L];
  assign e_out_d = all_out_d[L*W-1:0];
  assign w_out_d = all_out_d[NL*W-1:L*W];

  for (genvar d = 0; d < 2; d++) begin : g_dir
    for (genvar i = 0; i < L; i++) begin : g_link
      localparam int K = link_slice(link_dir_e'(d), i, L);

      mesh_link_fifo #(
        .WIDTH     (W),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_s     (all_in_s[K]),
        .in_d     (all_in_d[K*W +: W]),
        .in_r     (all_in_r[K]),
        .out_s    (all_out_s[K]),
        .out_d    (all_out_d[K*W +: W]),
        .out_r    (all_out_r[K])
`ifdef MESH_LINK_CNT_EN
        ,
        .flit_cnt (flit_cnt[K*CNT_WIDTH +: CNT_WIDTH])
`endif
      );
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mesh_row_links.sv
// tb_mesh_row_links: randomized scoreboard bench for the mesh row link fabric.
`default_nettype none

module tb_mesh_row_links;

  localparam int N_COLS = 4;
  localparam int L      = N_COLS - 1;
  localparam int NL     = 2 * L;
  localparam int W      = 64;
  localparam int D      = 4;
  localparam int CW     = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NL-1:0]   in_s = '0;
  logic [NL*W-1:0] in_d = '0;
  logic [NL-1:0]   in_r;
  logic [NL-1:0]   out_s;
  logic [NL*W-1:0] out_d;
  logic [NL-1:0]   out_r = '0;
`ifdef MESH_LINK_CNT_EN
  logic [NL*CW-1:0] flit_cnt;
`endif

  always #5 clk = ~clk;

  mesh_row_links #(
    .N_COLS       (N_COLS),
    .PACKET_WIDTH (W),
    .FIFO_DEPTH   (D),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e_in_s   (in_s[L-1:0]),
    .e_in_d   (in_d[L*W-1:0]),
    .e_in_r   (in_r[L-1:0]),
    .e_out_s  (out_s[L-1:0]),
    .e_out_d  (out_d[L*W-1:0]),
    .e_out_r  (out_r[L-1:0]),
    .w_in_s   (in_s[NL-1:L]),
    .w_in_d   (in_d[NL*W-1:L*W]),
    .w_in_r   (in_r[NL-1:L]),
    .w_out_s  (out_s[NL-1:L]),
    .w_out_d  (out_d[NL*W-1:L*W]),
    .w_out_r  (out_r[NL-1:L])
`ifdef MESH_LINK_CNT_EN
    ,
    .flit_cnt (flit_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] sb [NL][$];
  int          occ  [NL];
  int          pops [NL];

  initial begin
    for (int k = 0; k < NL; k++) begin
      occ[k]  = 0;
      pops[k] = 0;
    end
  end

  // Monitor: link model is just an occupancy number plus the expected-data queue.
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      logic         exp_r;
      logic         exp_s;
      logic [W-1:0] exp_d;
      exp_r = !reset && (occ[k] < D);
      exp_s = !reset && (occ[k] > 0) && out_r[k];
      checks++;
      if (in_r[k] !== exp_r) begin
        errors++;
        $display("FAIL in_r link%0d t=%0t got %b exp %b", k, $time, in_r[k], exp_r);
      end
      checks++;
      if (out_s[k] !== exp_s) begin
        errors++;
        $display("FAIL out_s link%0d t=%0t got %b exp %b", k, $time, out_s[k], exp_s);
      end
      if (out_s[k] === 1'b1) begin
        checks++;
        if (sb[k].size() == 0) begin
          errors++;
          $display("FAIL stray_flit link%0d t=%0t got %h exp none", k, $time, out_d[k*W +: W]);
        end else begin
          exp_d = sb[k].pop_front();
          if (out_d[k*W +: W] !== exp_d) begin
            errors++;
            $display("FAIL out_d link%0d t=%0t got %h exp %h", k, $time, out_d[k*W +: W], exp_d);
          end
        end
      end
      if (reset) begin
        occ[k]  = 0;
        pops[k] = 0;
        sb[k].delete();
      end else begin
        occ[k]  = occ[k] + int'(in_s[k] && exp_r) - int'(exp_s);
        pops[k] = pops[k] + int'(exp_s);
      end
    end
  end

  // One cycle of stimulus; the sender only raises in_s while ready is high.
  task automatic step(input bit r, input logic [NL-1:0] want, input logic [NL-1:0] ordy,
                      input bit fixed, input logic [W-1:0] fd);
    @(posedge clk);
    #1;
    reset = r;
    out_r = ordy;
    #1;
    for (int k = 0; k < NL; k++) begin
      logic [W-1:0] d;
      d = fixed ? fd : {$urandom(), $urandom()};
      in_d[k*W +: W] = d;
      in_s[k] = want[k] && in_r[k];
      if (in_s[k]) sb[k].push_back(d);
    end
  endtask

  localparam logic [NL-1:0] ALL = '1;
  localparam logic [NL-1:0] W1  = NL'(1) << (L + 1);

  initial begin
    repeat (3) step(1'b1, '0, '0, 1'b0, '0);

    // Single flit on east link 0.
    step(1'b0, NL'(1), ALL, 1'b1, 64'hA5);
    repeat (3) step(1'b0, '0, ALL, 1'b0, '0);

    // Fill west link 1 with its receiver stalled, then release.
    for (int v = 1; v <= 4; v++) step(1'b0, W1, ~W1, 1'b1, W'(v));
    step(1'b0, W1, ~W1, 1'b1, 64'hDEAD);
    repeat (6) step(1'b0, '0, ALL, 1'b0, '0);

    // Streaming at full rate on all links.
    repeat (20) step(1'b0, ALL, ALL, 1'b0, '0);
    repeat (3) step(1'b0, '0, ALL, 1'b0, '0);

    // Fill everything, then push and pop together while full.
    repeat (4) step(1'b0, ALL, '0, 1'b0, '0);
    step(1'b0, ALL, ALL, 1'b0, '0);
    step(1'b0, ALL, ALL, 1'b0, '0);
    repeat (6) step(1'b0, '0, ALL, 1'b0, '0);

    // Randomized traffic with random backpressure.
    repeat (1500) step(1'b0, NL'($urandom()), NL'($urandom()), 1'b0, '0);

    // Reset with flits queued; nothing stale may emerge afterwards.
    repeat (2) step(1'b0, ALL, '0, 1'b0, '0);
    repeat (2) step(1'b1, ALL, ALL, 1'b0, '0);
    repeat (5) step(1'b0, '0, ALL, 1'b0, '0);

    // 17 pops on east link 0 only.
    for (int n = 0; n < 17; n++) step(1'b0, NL'(1), ALL, 1'b0, '0);
    repeat (8) step(1'b0, '0, ALL, 1'b0, '0);

    @(negedge clk);
    #1;
    for (int k = 0; k < NL; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL drain link%0d got %0d left exp 0", k, sb[k].size());
      end
`ifdef MESH_LINK_CNT_EN
      checks++;
      if (flit_cnt[k*CW +: CW] !== CW'(pops[k])) begin
        errors++;
        $display("FAIL flit_cnt link%0d got %0d exp %0d", k, flit_cnt[k*CW +: CW], CW'(pops[k]));
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
